// File: rtl/result_arbiter_if.sv
// result_arbiter_if
//   Bundles the worker-result handshake and the frame-buffer write port that
//   result_arbiter sits between.
//   Parameters: NUM_WORKERS (worker count), ITER_W (iteration-count width).
//   Worker side : start, jw_ra_req, jw_ra_x, jw_ra_y, jw_ra_iter -> arbiter
//                 ra_jw_ack <- arbiter
//   Frame buffer: fb_ready -> arbiter
//                 fb_wr_en, fb_addr, fb_data <- arbiter
//   Status      : frame_done, range_err <- arbiter
//   modport master: the arbiter.  modport slave: the workers and frame buffer.
interface result_arbiter_if #(
  parameter int NUM_WORKERS = 16,
  parameter int ITER_W      = 8
);
  logic                          start;
  logic [NUM_WORKERS-1:0]        jw_ra_req;
  logic [NUM_WORKERS*10-1:0]     jw_ra_x;
  logic [NUM_WORKERS*10-1:0]     jw_ra_y;
  logic [NUM_WORKERS*ITER_W-1:0] jw_ra_iter;
  logic [NUM_WORKERS-1:0]        ra_jw_ack;
  logic                          fb_ready;
  logic                          fb_wr_en;
  logic [18:0]                   fb_addr;
  logic [ITER_W-1:0]             fb_data;
  logic                          frame_done;
  logic                          range_err;

  modport master (
    input  start, jw_ra_req, jw_ra_x, jw_ra_y, jw_ra_iter, fb_ready,
    output ra_jw_ack, fb_wr_en, fb_addr, fb_data, frame_done, range_err
  );

  modport slave (
    output start, jw_ra_req, jw_ra_x, jw_ra_y, jw_ra_iter, fb_ready,
    input  ra_jw_ack, fb_wr_en, fb_addr, fb_data, frame_done, range_err
  );
endinterface

// File: rtl/result_arbiter.sv
// result_arbiter
//   Collects finished pixels from NUM_WORKERS Julia workers through a
//   round-robin arbiter and writes them to the frame buffer at linear address
//   y*(XMAX+1)+x. Pixels with coordinates outside the frame are dropped and
//   flagged in the sticky range_err. frame_done rises once every pixel of the
//   frame has been written; start re-arms for the next frame.
//   Parameters: NUM_WORKERS, ITER_W, XMAX/YMAX (last valid column/row).
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - result_arbiter_if.master (worker handshake, fb write port, status)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   ARB   | searching for a requesting worker from ptr, wrapping
//   WRITE | fb_wr_en high, addr/data held until fb_ready
//   DONE  | whole frame written, frame_done held, requests ignored
module result_arbiter #(
  parameter int NUM_WORKERS = 16,
  parameter int ITER_W      = 8,
  parameter int XMAX        = 639,
  parameter int YMAX        = 479
) (
  input  logic               clk,
  input  logic               rst,
  result_arbiter_if.master   bus
);

  localparam int          PTR_W     = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [18:0] LINE_LEN  = 19'(XMAX + 1);
  localparam logic [18:0] FRAME_PIX = 19'((XMAX + 1) * (YMAX + 1));
  localparam logic [9:0]  X_LAST    = 10'(XMAX);
  localparam logic [9:0]  Y_LAST    = 10'(YMAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_WORKERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic [18:0]            pix_cnt;
  logic [NUM_WORKERS-1:0] ack_q;
  logic                   wr_en_q;
  logic [18:0]            addr_q;
  logic [ITER_W-1:0]      data_q;
  logic                   done_q;
  logic                   err_q;

  // A worker whose ack is on the wire this cycle still shows req (it only
  // sees the ack at the coming edge), so it must not win again yet.
  logic [NUM_WORKERS-1:0] eligible;
  assign eligible = bus.jw_ra_req & ~ack_q;

  // Round-robin search: first eligible worker at or after ptr, wrapping.
  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_WORKERS);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Result fields of the granted worker.
  logic [9:0]        sel_x;
  logic [9:0]        sel_y;
  logic [ITER_W-1:0] sel_iter;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_iter = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (PTR_W'(i) == gnt_idx) begin
        sel_x    = bus.jw_ra_x[i*10 +: 10];
        sel_y    = bus.jw_ra_y[i*10 +: 10];
        sel_iter = bus.jw_ra_iter[i*ITER_W +: ITER_W];
      end
    end
  end

  logic                   in_range;
  logic [18:0]            lin_addr;
  logic [PTR_W-1:0]       next_ptr;
  logic [NUM_WORKERS-1:0] gnt_onehot;

  assign in_range   = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
  // Full 19-bit product: 479*640+639 = 307199 fits without truncation.
  assign lin_addr   = ({9'd0, sel_y} * LINE_LEN) + {9'd0, sel_x};
  assign next_ptr   = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
  assign gnt_onehot = NUM_WORKERS'(1) << gnt_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      pix_cnt <= '0;
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // ack is a single-cycle pulse unless re-armed below.
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pix_cnt <= '0;
            err_q   <= 1'b0;
            ptr     <= '0;
            state   <= ARB;
          end
        end

        ARB: begin
          if (gnt_found) begin
            ack_q <= gnt_onehot;
            ptr   <= next_ptr;
            if (in_range) begin
              addr_q  <= lin_addr;
              data_q  <= sel_iter;
              wr_en_q <= 1'b1;
              state   <= WRITE;
            end else begin
              // Dropped pixel: consumed (acked) but never written or counted.
              err_q <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (bus.fb_ready) begin
            wr_en_q <= 1'b0;
            pix_cnt <= pix_cnt + 19'd1;
            if (pix_cnt + 19'd1 == FRAME_PIX) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state <= ARB;
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            done_q  <= 1'b0;
            pix_cnt <= '0;
            err_q   <= 1'b0;
            ptr     <= '0;
            state   <= ARB;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ra_jw_ack  = ack_q;
  assign bus.fb_wr_en   = wr_en_q;
  assign bus.fb_addr    = addr_q;
  assign bus.fb_data    = data_q;
  assign bus.frame_done = done_q;
  assign bus.range_err  = err_q;

endmodule
